// File: rtl/sram_port_arbiter.sv
// Zero-fill sequencer and round-robin read/write arbiter for one byte-masked SRAM macro.
// Optional perf counters are compiled in with `define SRAM_ARB_PERF_EN.
module sram_port_arbiter #(
  parameter  int NUM_RD = 4,
  parameter  int DEPTH  = 512,
  parameter  int DW     = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int IDW    = $clog2(NUM_RD),
  localparam int MW     = DW / 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_RD-1:0]   rd_req_valid,
  input  logic [NUM_RD*AW-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]   rd_req_ready,
  output logic                rd_rsp_valid,
  output logic [IDW-1:0]      rd_rsp_id,
  output logic [DW-1:0]       rd_rsp_data,
  input  logic [1:0]          wr_req_valid,
  input  logic [2*AW-1:0]     wr_req_addr,
  input  logic [2*DW-1:0]     wr_req_data,
  input  logic [2*MW-1:0]     wr_req_mask,
  output logic [1:0]          wr_req_ready,
  output logic                init_done,
  output logic                mem_w_en,
  output logic [AW-1:0]       mem_w_addr,
  output logic [DW-1:0]       mem_w_data,
  output logic [MW-1:0]       mem_w_mask,
  output logic                mem_r_en,
  output logic [AW-1:0]       mem_r_addr,
  input  logic [DW-1:0]       mem_r_data
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_rd_conflict,
  output logic [31:0]         perf_wr_stall
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [IDW-1:0]  rd_ptr_q;
  logic            wr_ptr_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            last_rd_v_q;
  logic [AW-1:0]   last_rd_addr_q;
  logic [MW-1:0]   fwd_mask_q;
  logic [DW-1:0]   fwd_data_q;

  logic [AW-1:0]   rd_addr [NUM_RD];
  logic [AW-1:0]   wr_addr [2];
  logic [DW-1:0]   wr_data [2];
  logic [MW-1:0]   wr_mask [2];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign rd_addr[i] = rd_req_addr[i*AW +: AW];
  end
  for (genvar j = 0; j < 2; j++) begin : g_wr_unpack
    assign wr_addr[j] = wr_req_addr[j*AW +: AW];
    assign wr_data[j] = wr_req_data[j*DW +: DW];
    assign wr_mask[j] = wr_req_mask[j*MW +: MW];
  end

  // Returns {found, index} of the first valid requester at or after the pointer.
  function automatic logic [IDW:0] rd_pick(input logic [NUM_RD-1:0] v,
                                           input logic [IDW-1:0]   p);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    int             k;
    r = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      k = int'(p) + i;
      if (k >= NUM_RD) k = k - NUM_RD;
      idx = IDW'(k);
      if (!r[IDW] && v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic           run;
  logic           rd_any, rd_gnt;
  logic [IDW-1:0] rd_sel;
  logic [1:0]     wr_elig;
  logic           wr_any, wr_gnt;
  logic           wr_sel;

  assign run              = (state_q == ST_RUN);
  assign {rd_any, rd_sel} = rd_pick(rd_req_valid, rd_ptr_q);
  assign rd_gnt           = run & rd_any;

  // A write to the address read last cycle is withheld so that read sees the old data.
  always_comb begin
    for (int j = 0; j < 2; j++)
      wr_elig[j] = wr_req_valid[j] & ~(last_rd_v_q && (wr_addr[j] == last_rd_addr_q));
  end

  always_comb begin
    wr_any = 1'b0;
    wr_sel = wr_ptr_q;
    if (wr_elig[wr_ptr_q]) begin
      wr_any = 1'b1;
    end else if (wr_elig[~wr_ptr_q]) begin
      wr_any = 1'b1;
      wr_sel = ~wr_ptr_q;
    end
  end
  assign wr_gnt = run & wr_any;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rd_req_ready = '0;
    wr_req_ready = '0;
    mem_w_en     = 1'b0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    mem_w_mask   = '0;
    mem_r_en     = 1'b0;
    mem_r_addr   = '0;
    unique case (state_q)
      ST_INIT: begin
        // Gated by reset_n so the macro sees no write while reset is held.
        mem_w_en   = reset_n;
        mem_w_addr = init_cnt_q;
        mem_w_mask = '1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_req_ready[rd_sel] = rd_any;
        wr_req_ready[wr_sel] = wr_any;
        mem_r_en             = rd_any;
        mem_r_addr           = rd_addr[rd_sel];
        mem_w_en             = wr_any;
        mem_w_addr           = wr_addr[wr_sel];
        mem_w_data           = wr_data[wr_sel];
        mem_w_mask           = wr_mask[wr_sel];
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      last_rd_v_q <= 1'b0;
      fwd_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rsp_valid_q <= rd_gnt;
      last_rd_v_q <= rd_gnt;
      fwd_mask_q  <= (rd_gnt && wr_gnt && (rd_addr[rd_sel] == wr_addr[wr_sel]))
                     ? wr_mask[wr_sel] : '0;
      if (rd_gnt) begin
        rd_ptr_q <= (rd_sel == IDW'(NUM_RD - 1)) ? '0 : rd_sel + 1'b1;
        rsp_id_q <= rd_sel;
      end
      if (wr_gnt) wr_ptr_q <= ~wr_sel;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are only consumed when qualified.
  always_ff @(posedge clock) begin
    last_rd_addr_q <= rd_addr[rd_sel];
    fwd_data_q     <= wr_data[wr_sel];
  end

  // Same-cycle write to the read address: the macro returns old data, so merge the new bytes here.
  for (genvar b = 0; b < MW; b++) begin : g_fwd
    assign rd_rsp_data[b*8 +: 8] = fwd_mask_q[b] ? fwd_data_q[b*8 +: 8] : mem_r_data[b*8 +: 8];
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_id    = rsp_id_q;
  assign init_done    = run;

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_conflict <= '0;
      perf_wr_stall    <= '0;
    end else if (run) begin
      if (($countones(rd_req_valid) >= 2) && (perf_rd_conflict != '1))
        perf_rd_conflict <= perf_rd_conflict + 1'b1;
      if (((wr_req_valid & ~wr_req_ready) != 2'b00) && (perf_wr_stall != '1))
        perf_wr_stall <= perf_wr_stall + 1'b1;
    end
  end
`endif

endmodule
